reorder_buffer: RTL and testbench
=================================

# reorder_buffer

In-order commit queue for the Tomasulo core; sits directly upstream of the register file. Allocates a 4-bit tag per dispatched instruction, which the register file records as the rename tag for `rd`. Captures results broadcast on the CDB and retires entries strictly in program order. Each retirement is presented as one commit beat `{rdy, tag, data, rd}` that the register file consumes.

## Interface
- `DEPTH`, 16: number of entries; must equal 2^TAG_W.
- `TAG_W`, 4: tag width; the tag is the entry index.
- `XLEN`, 32: data width.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: discard all entries (mispredict/exception).
- `alloc_valid` in 1: dispatch requests an entry this cycle.
- `alloc_rd` in 5: destination register of the dispatching instruction.
- `alloc_ready` out 1: an entry is free (count < DEPTH).
- `alloc_tag` out TAG_W: tag granted to the current request (= tail).
- `cdb_valid` in 1: result broadcast valid.
- `cdb_tag` in TAG_W: producing entry's tag.
- `cdb_data` in XLEN: result value.
- `commit_rdy` out 1: the head entry retires this cycle.
- `commit_tag` out TAG_W: head tag.
- `commit_data` out XLEN: head result.
- `commit_rd` out 5: head destination register.
- `count` out TAG_W+1: occupied entries, 0..DEPTH.

## Operation
- Storage: DEPTH entries, each holding `valid`, `ready`, `rd`, `data`. State also includes `head` and `tail` (TAG_W bits each, wrap mod DEPTH) and `count`.
- Allocate: fires when `alloc_valid && alloc_ready`.
  - Writes entry[tail] = {valid=1, ready=0, rd=alloc_rd, data=0}.
  - Increments tail.
  - If `alloc_valid` is asserted while full, the request is ignored with no state change.
- Write-back: fires when `cdb_valid` and entry[cdb_tag].valid.
  - Sets ready=1 and data=cdb_data.
  - A CDB hit on an invalid entry is ignored.
  - A CDB hit on an entry that is already ready overwrites its data; this is legal but is not expected to occur.
- Commit: `commit_rdy` = entry[head].valid && entry[head].ready.
  - When `commit_rdy` is high, the entry is cleared (valid=0, ready=0) and head increments.
  - At most one entry commits per cycle.
  - Entries with `rd`=0 commit normally; the register file ignores x0.
- `count` next value = count + alloc_fire − commit_fire.
- Priority:
  - rst/flush: clear every valid/ready bit and set head=tail=count=0. This overrides alloc, CDB and commit in the same cycle.
  - While flush is high, `commit_rdy` is forced to 0.
- Simultaneous events:
  - Alloc and commit in the same cycle: both take effect.
  - Full with commit: alloc_ready stays 0 that cycle (no same-cycle bypass).
  - Empty: an entry allocated this cycle cannot commit this cycle.
  - CDB hit on the head in the same cycle as that head is evaluated: commit uses the pre-edge state, so the entry commits next cycle.
  - CDB tag equal to the tail being allocated this cycle: ignored, because the entry is not yet valid.

## Timing
- Reset values: alloc_ready=1, alloc_tag=0, commit_rdy=0, commit_tag=0, commit_data=0, commit_rd=0, count=0.
- `alloc_ready`, `alloc_tag`, `commit_*` and `count` are combinational from registered state only; there is no input-to-output path.
- Latency:
  - Allocate to earliest commit: 2 cycles (alloc at edge N, CDB at cycle N+1 edge, commit visible at cycle N+2).
  - CDB to commit visible: 1 cycle.
- Throughput: one allocation plus one commit per cycle.
- The register file samples the commit beat at the same edge where head advances.

## Structure
- Package `rv32i_types` holds:
  - `rob_entry_t` {valid, ready, rd[4:0], data[XLEN-1:0]}.
  - `ROB_DEPTH`=16 and `ROB_TAG_W`=4.
  - The commit beat, assembled into the existing `sal_t` {rdy, tag, data} plus `commit_rd`.
- `ROB_TAG_W` must match the register file's tag width.
- No sub-module; the circular-pointer logic is small and remains inline.

## Test plan
- Reset → alloc_ready=1, alloc_tag=0, commit_rdy=0, count=0.
- Allocate rd=5 (tag 0), then rd=6 (tag 1). CDB {tag1, 0xBEEF}, then CDB {tag0, 0x1234} → one cycle after the tag-0 CDB, commit {tag0, rd5, 0x1234}; next cycle commit {tag1, rd6, 0xBEEF}; count reaches 0.
- 16 back-to-back allocs → alloc_ready=0 at count=16; a 17th alloc_valid leaves state unchanged. Complete and commit tag 0 → alloc_ready=1 and alloc_tag=0 (wrap).
- At count=15 with head ready, alloc and commit in the same cycle → count stays 15; the new tail tag is the previous tail+1 mod 16.
- 3 entries in flight with the head ready; assert flush → commit_rdy=0 that cycle; next cycle count=0, alloc_tag=0, and a subsequent CDB to tag 1 is ignored.
- CDB {tag 7, 0xDEAD} while entry 7 is invalid → no commit ever issues for it; a later allocation of tag 7 starts with ready=0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the Tomasulo core: reorder buffer entry,
// sizing constants and the commit beat consumed by the register file.
package rv32i_types;

  localparam int ROB_XLEN  = 32;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = 4;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [4:0]          rd;
    logic [ROB_XLEN-1:0] data;
  } rob_entry_t;

  typedef struct packed {
    logic                 rdy;
    logic [ROB_TAG_W-1:0] tag;
    logic [ROB_XLEN-1:0]  data;
  } sal_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit queue: allocates tags at dispatch, captures CDB results,
// retires the head each cycle it is ready.
// Ports: clk, rst (sync, active-high), flush, alloc_valid/alloc_rd ->
// alloc_ready/alloc_tag, cdb_valid/cdb_tag/cdb_data, commit_rdy/commit_tag/
// commit_data/commit_rd, count.
module reorder_buffer
  import rv32i_types::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = ROB_TAG_W,
  parameter int XLEN  = ROB_XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  output logic             commit_rdy,
  output logic [TAG_W-1:0] commit_tag,
  output logic [XLEN-1:0]  commit_data,
  output logic [4:0]       commit_rd,
  output logic [TAG_W:0]   count
);

  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

  rob_entry_t       rob [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   cnt;

  rob_entry_t hd;
  sal_t       beat;
  logic       alloc_fire;
  logic       commit_fire;

  assign hd          = rob[head];
  assign alloc_ready = (cnt < FULL);
  assign alloc_tag   = tail;
  assign count       = cnt;

  assign beat.rdy  = hd.valid & hd.ready & ~flush;
  assign beat.tag  = head;
  assign beat.data = hd.data;

  assign commit_rdy  = beat.rdy;
  assign commit_tag  = beat.tag;
  assign commit_data = beat.data;
  assign commit_rd   = hd.rd;

  assign alloc_fire  = alloc_valid & alloc_ready;
  assign commit_fire = beat.rdy;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob[i] <= '0;
      end
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      // Tail entry is invalid until the edge it is allocated on,
      // so a same-cycle CDB hit on it falls through the valid check.
      if (cdb_valid && rob[cdb_tag].valid) begin
        rob[cdb_tag].ready <= 1'b1;
        rob[cdb_tag].data  <= cdb_data;
      end
      if (commit_fire) begin
        rob[head].valid <= 1'b0;
        rob[head].ready <= 1'b0;
        head <= head + TAG_W'(1);
      end
      if (alloc_fire) begin
        rob[tail].valid <= 1'b1;
        rob[tail].ready <= 1'b0;
        rob[tail].rd    <= alloc_rd;
        rob[tail].data  <= '0;
        tail <= tail + TAG_W'(1);
      end
      unique case ({alloc_fire, commit_fire})
        2'b10:   cnt <= cnt + (TAG_W+1)'(1);
        2'b01:   cnt <= cnt - (TAG_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: program-order queue model
// compared every cycle, plus directed literal checks.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        commit_rdy;
  logic [3:0]  commit_tag;
  logic [31:0] commit_data;
  logic [4:0]  commit_rd;
  logic [4:0]  count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_rdy(commit_rdy), .commit_tag(commit_tag),
    .commit_data(commit_data), .commit_rd(commit_rd),
    .count(count)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  rd;
    bit          rdy;
    logic [31:0] data;
  } ent_t;

  ent_t       q[$];
  logic [3:0] next_tag = 4'd0;

  function automatic bit m_commit();
    return (q.size() > 0) && q[0].rdy && !flush;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_alloc_ready", 32'(alloc_ready), 32'(q.size() < 16));
      chk("m_alloc_tag", 32'(alloc_tag), 32'(next_tag));
      chk("m_count", 32'(count), 32'(q.size()));
      chk("m_commit_rdy", 32'(commit_rdy), 32'(m_commit()));
      if (m_commit()) begin
        chk("m_commit_tag", 32'(commit_tag), 32'(q[0].tag));
        chk("m_commit_data", commit_data, q[0].data);
        chk("m_commit_rd", 32'(commit_rd), 32'(q[0].rd));
      end
    end
  end

  task automatic step(input bit av, input logic [4:0] rd,
                      input bit cv, input logic [3:0] tg,
                      input logic [31:0] d, input bit fl);
    bit c, a;
    alloc_valid = av;
    alloc_rd    = rd;
    cdb_valid   = cv;
    cdb_tag     = tg;
    cdb_data    = d;
    flush       = fl;
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
      next_tag = 4'd0;
    end else begin
      c = m_commit();
      a = av && (q.size() < 16);
      if (cv) begin
        foreach (q[i]) begin
          if (q[i].tag == tg) begin
            q[i].rdy  = 1'b1;
            q[i].data = d;
          end
        end
      end
      if (c) void'(q.pop_front());
      if (a) begin
        q.push_back('{tag: next_tag, rd: rd, rdy: 1'b0, data: 32'h0});
        next_tag = next_tag + 4'd1;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(0, 5'd0, 0, 4'd0, 32'h0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    alloc_valid = 1'b0;
    alloc_rd = '0;
    cdb_valid = 1'b0;
    cdb_tag = '0;
    cdb_data = '0;
    do_reset();
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    chk("rst_commit_rdy", 32'(commit_rdy), 32'd0);
    chk("rst_commit_data", commit_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);

    step(1, 5'd5, 0, 4'd0, 32'h0, 0);
    step(1, 5'd6, 0, 4'd0, 32'h0, 0);
    step(0, 5'd0, 1, 4'd1, 32'hBEEF, 0);
    chk("ooo_no_commit", 32'(commit_rdy), 32'd0);
    step(0, 5'd0, 1, 4'd0, 32'h1234, 0);
    chk("c0_rdy", 32'(commit_rdy), 32'd1);
    chk("c0_tag", 32'(commit_tag), 32'd0);
    chk("c0_rd", 32'(commit_rd), 32'd5);
    chk("c0_data", commit_data, 32'h1234);
    idle();
    chk("c1_tag", 32'(commit_tag), 32'd1);
    chk("c1_rd", 32'(commit_rd), 32'd6);
    chk("c1_data", commit_data, 32'hBEEF);
    idle();
    chk("drain_count", 32'(count), 32'd0);

    do_reset();
    for (int i = 0; i < 16; i++) step(1, 5'(i + 1), 0, 4'd0, 32'h0, 0);
    chk("full_ready", 32'(alloc_ready), 32'd0);
    chk("full_count", 32'(count), 32'd16);
    step(1, 5'd31, 0, 4'd0, 32'h0, 0);
    chk("full_ign_count", 32'(count), 32'd16);
    step(0, 5'd0, 1, 4'd0, 32'h0A0A, 0);
    chk("full_commit_no_bypass", 32'(alloc_ready), 32'd0);
    idle();
    chk("wrap_ready", 32'(alloc_ready), 32'd1);
    chk("wrap_tag", 32'(alloc_tag), 32'd0);
    chk("wrap_count", 32'(count), 32'd15);

    step(0, 5'd0, 1, 4'd1, 32'h5555, 0);
    step(1, 5'd9, 0, 4'd0, 32'h0, 0);
    chk("ac_count", 32'(count), 32'd15);
    chk("ac_tag", 32'(alloc_tag), 32'd1);

    do_reset();
    step(1, 5'd1, 0, 4'd0, 32'h0, 0);
    step(1, 5'd2, 0, 4'd0, 32'h0, 0);
    step(1, 5'd3, 0, 4'd0, 32'h0, 0);
    step(0, 5'd0, 1, 4'd0, 32'h77, 0);
    chk("pre_flush_rdy", 32'(commit_rdy), 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_rdy", 32'(commit_rdy), 32'd0);
    step(0, 5'd0, 0, 4'd0, 32'h0, 1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_tag", 32'(alloc_tag), 32'd0);
    step(0, 5'd0, 1, 4'd1, 32'h99, 0);
    idle();
    chk("flush_cdb_ign", 32'(commit_rdy), 32'd0);

    step(0, 5'd0, 1, 4'd7, 32'hDEAD, 0);
    for (int i = 0; i < 8; i++) step(1, 5'(i), 0, 4'd0, 32'h0, 0);
    idle();
    chk("t7_count", 32'(count), 32'd8);
    chk("t7_no_commit", 32'(commit_rdy), 32'd0);
    step(1, 5'd0, 1, 4'd7, 32'h700, 0);
    for (int i = 0; i < 7; i++) step(0, 5'd0, 1, 4'(i), 32'(i + 16), 0);
    for (int i = 0; i < 10; i++) idle();
    chk("t7_drain", 32'(count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
